upcoin_spi_master: RTL and testbench
====================================

// Module: upcoin_spi_master
// PURPOSE
//  Host-side SPI master for the uPcoin SHA-256 core. Takes 512-bit padded blocks on a valid/ready
//  interface, shifts each into the core, sequences block_load/message_load, waits for done and
//  shifts the 256-bit hash back out. Same clk domain as the core; drives its sck/sdi/load pins.
// PARAMETERS
//  CLK_DIV    4   clk cycles per sck half-period (>=2)
//  HASH_WAIT  80  clk cycles held after block_load falls before the next block or final release
//  TIMEOUT    256 clk cycles allowed in WAIT_DONE (UPCOIN_SPI_TIMEOUT_EN only)
// PORTS
//  clk          in   1    system clock, shared with the core
//  reset        in   1    synchronous, active-high
//  blk_valid    in   1    block/blk_last valid
//  blk_ready    out  1    master can accept a block
//  block        in   512  padded message block; bit 511 is sent first
//  blk_last     in   1    final block of the message
//  hash         out  256  digest; held until the next accepted message
//  hash_valid   out  1    one-cycle pulse when hash is updated
//  busy         out  1    high from first block accept to hash_valid
//  sck          out  1    SPI clock to the core, idle low
//  sdo          out  1    serial data to core sdi; changes only while sck is low
//  sdi          in   1    serial data from core sdo; sampled on sck rise
//  block_load   out  1    high while shifting a block; its fall starts hashing
//  message_load out  1    high for the whole message; its fall ends the message
//  done         in   1    core finished hashing
// BEHAVIOUR
//  Reset: FSM IDLE; sck, sdo, block_load, message_load, busy, hash_valid, blk_ready=0; hash=0;
//   counters=0. Reset mid-transfer aborts immediately with no partial hash_valid.
//  Accept: blk_valid&&blk_ready for one cycle; block and blk_last latched. blk_ready=1 only in
//   IDLE and NEXT. blk_valid in any other state is ignored.
//  FSM: IDLE -> LOAD(1 cyc: message_load=1, block_load=1) -> SHIFT -> KICK -> {NEXT | RELEASE}.
//   NEXT -> LOAD on accept. RELEASE(message_load=0) -> WAIT_DONE -> READ -> FIN -> IDLE.
//  LOAD entered from NEXT leaves message_load at 1.
//  SHIFT: 512 sck periods; sck rises after CLK_DIV clk with bit valid, falls CLK_DIV later.
//   sdo=shift[511] and shift<<=1 on each sck fall. 9-bit counter ends SHIFT after rise #512
//   plus its fall.
//  KICK: block_load=0, hold HASH_WAIT cycles, then go to NEXT if !last_q, else RELEASE.
//  RELEASE: one cycle with message_load=0, block_load=0.
//  WAIT_DONE: wait for done=1. The core already drives hash[255] on sdi at that point.
//  READ: 256 sck periods with sdo=0. On each rise: hash_sr={hash_sr[254:0],sdi}.
//  FIN: hash<=hash_sr, hash_valid=1, busy=0.
//  sck stays low outside SHIFT/READ, and block_load=0 outside LOAD/SHIFT.
//  Counters: div counter wraps at CLK_DIV-1; bit counter wraps 511->0 in SHIFT and 255->0 in READ.
//  Simultaneous events: reset dominates everything. done before WAIT_DONE is ignored until
//   WAIT_DONE is reached.
// CONFIGURATION
//  UPCOIN_SPI_TIMEOUT_EN defined: adds output `timeout` (1 bit, reset 0).
//   WAIT_DONE exceeding TIMEOUT cycles -> timeout pulses 1 cycle, FSM goes IDLE, no hash_valid.
//  Undefined: no port and no counter; WAIT_DONE waits indefinitely.
// STRUCTURE
//  upcoin_pkg:
//   typedef enum spi_state_t {IDLE, LOAD, SHIFT, KICK, NEXT, RELEASE, WAIT_DONE, READ, FIN}
//   localparams MSG_BITS=512, HASH_BITS=256
//  Sub-module upcoin_sck_gen(clk, reset, en, sck, rise, fall): divider, one-cycle rise/fall strobes.
// TESTING  (bench instantiates uPcoin core on same clk)
//  "abc" one block 61626380_00..00_00000018, blk_last=1
//   -> hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, one hash_valid.
//  Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"
//   -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
//   message_load high across both blocks.
//  Bit order: block=1<<511 -> sdo=1 at first sck rise only, 511 zeros follow;
//   exactly 512 rises in SHIFT and 256 in READ.
//  Reset asserted at bit 200 of SHIFT -> next cycle sck=0, block_load=0, message_load=0,
//   blk_ready=0, then IDLE. A new "abc" run then gives the correct hash.
//  blk_valid pulsed during SHIFT/READ -> ignored, blk_ready=0, hash unchanged.
//  TIMEOUT_EN, done tied 0 -> timeout after 256 WAIT_DONE cycles, hash_valid never rises.

Source files
------------

// File: rtl/upcoin_pkg.sv
// Shared types and sizes for the uPcoin SHA-256 host-side SPI master.
package upcoin_pkg;

  localparam int MSG_BITS  = 512;
  localparam int HASH_BITS = 256;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SHIFT,
    KICK,
    NEXT,
    RELEASE,
    WAIT_DONE,
    READ,
    FIN
  } spi_state_t;

endpackage

// File: rtl/upcoin_sck_gen.sv
// SPI clock divider: sck toggles every CLK_DIV clk cycles while enabled, with
// registered one-cycle strobes that coincide with the new sck level.
module upcoin_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div  <= '0;
      sck  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (div == DIV_W'(CLK_DIV - 1)) begin
        div  <= '0;
        sck  <= ~sck;
        rise <= ~sck;
        fall <= sck;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/upcoin_spi_master.sv
// Host-side SPI master feeding 512-bit blocks into the uPcoin SHA-256 core and reading back the digest.
// Optional WAIT_DONE watchdog enabled by defining UPCOIN_SPI_TIMEOUT_EN.
module upcoin_spi_master
  import upcoin_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int HASH_WAIT = 80,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [MSG_BITS-1:0]  block,
  input  logic                 blk_last,
  output logic [HASH_BITS-1:0] hash,
  output logic                 hash_valid,
  output logic                 busy,
  output logic                 sck,
  output logic                 sdo,
  input  logic                 sdi,
  output logic                 block_load,
  output logic                 message_load,
  input  logic                 done
`ifdef UPCOIN_SPI_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  localparam int WAIT_MAX = (HASH_WAIT > TIMEOUT) ? HASH_WAIT : TIMEOUT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  spi_state_t            state;
  logic [8:0]            bit_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  last_q;
  logic [MSG_BITS-1:0]   shift;
  logic [HASH_BITS-1:0]  hash_sr;
  logic                  sck_en;
  logic                  rise;
  logic                  fall;
  logic                  accept;

  assign accept = blk_valid && blk_ready;
  assign sck_en = (state == SHIFT) || (state == READ);

  upcoin_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sck_en),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

  // Datapath: block shifter and digest collector carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift <= block;
    end else if (state == SHIFT && fall) begin
      shift <= {shift[MSG_BITS-2:0], 1'b0};
    end
    if (state == READ && rise) begin
      hash_sr <= {hash_sr[HASH_BITS-2:0], sdi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      last_q       <= 1'b0;
      blk_ready    <= 1'b0;
      busy         <= 1'b0;
      hash_valid   <= 1'b0;
      hash         <= '0;
      sdo          <= 1'b0;
      block_load   <= 1'b0;
      message_load <= 1'b0;
`ifdef UPCOIN_SPI_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      hash_valid <= 1'b0;
`ifdef UPCOIN_SPI_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (accept) begin
            blk_ready    <= 1'b0;
            last_q       <= blk_last;
            busy         <= 1'b1;
            message_load <= 1'b1;
            block_load   <= 1'b1;
            state        <= LOAD;
          end
        end
        NEXT: begin
          if (accept) begin
            blk_ready  <= 1'b0;
            last_q     <= blk_last;
            block_load <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          sdo     <= shift[MSG_BITS-1];
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        // The first bit is already on sdo; each fall presents the next one.
        SHIFT: begin
          if (fall) begin
            sdo     <= shift[MSG_BITS-2];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 9'd511) begin
              sdo        <= 1'b0;
              block_load <= 1'b0;
              wait_cnt   <= '0;
              state      <= KICK;
            end
          end
        end
        KICK: begin
          if (wait_cnt == WAIT_W'(HASH_WAIT - 1)) begin
            wait_cnt <= '0;
            if (last_q) begin
              message_load <= 1'b0;
              state        <= RELEASE;
            end else begin
              blk_ready <= 1'b1;
              state     <= NEXT;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RELEASE: begin
          wait_cnt <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            bit_cnt <= '0;
            state   <= READ;
          end
`ifdef UPCOIN_SPI_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // The core presents each digest bit before the rise that samples it.
        READ: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 9'd255) begin
              bit_cnt    <= '0;
              hash       <= hash_sr;
              hash_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upcoin_spi_master.sv
// Bench for upcoin_spi_master with a behavioural SHA-256 core model on the SPI pins.
module tb_upcoin_spi_master;

  localparam int CLK_DIV   = 4;
  localparam int HASH_WAIT = 80;
  localparam int TIMEOUT   = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] block = '0;
  logic         blk_last = 1'b0;
  logic [255:0] hash;
  logic         hash_valid;
  logic         busy;
  logic         sck;
  logic         sdo;
  logic         sdi;
  logic         block_load;
  logic         message_load;
  logic         done;
`ifdef UPCOIN_SPI_TIMEOUT_EN
  logic         timeout;
`endif

  always #5 clk = ~clk;

  upcoin_spi_master #(
    .CLK_DIV(CLK_DIV),
    .HASH_WAIT(HASH_WAIT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .block(block),
    .blk_last(blk_last),
    .hash(hash),
    .hash_valid(hash_valid),
    .busy(busy),
    .sck(sck),
    .sdo(sdo),
    .sdi(sdi),
    .block_load(block_load),
    .message_load(message_load),
    .done(done)
`ifdef UPCOIN_SPI_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Core model plus pin monitor, evaluated on the falling clk edge.
  logic [255:0] core_h = '0;
  logic [255:0] out_sr = '0;
  logic [511:0] core_blk = '0;
  logic         core_done = 1'b0;
  logic         core_mute = 1'b0;
  logic         sck_prev = 1'b0, bl_prev = 1'b0, ml_prev = 1'b0;
  logic         first_bit = 1'b0;
  int           sh_blk = 0, sh_ones = 0, rd_rises = 0;
  int           hv_cnt = 0, ml_falls = 0, bl_falls = 0;

  assign sdi  = out_sr[255];
  assign done = core_done;

  always @(negedge clk) begin
    if (message_load && !ml_prev) begin
      core_h    = IV;
      core_done = 1'b0;
      rd_rises  = 0;
    end
    if (block_load && !bl_prev) begin
      sh_blk    = 0;
      sh_ones   = 0;
      first_bit = 1'b0;
    end
    if (sck && !sck_prev) begin
      if (block_load) begin
        core_blk = {core_blk[510:0], sdo};
        sh_blk++;
        if (sdo) sh_ones++;
        if (sh_blk == 1) first_bit = sdo;
      end else if (!message_load) begin
        rd_rises++;
      end
    end
    if (!block_load && bl_prev) begin
      core_h = sha_comp(core_h, core_blk);
      bl_falls++;
    end
    if (!message_load && ml_prev) begin
      out_sr    = core_h;
      core_done = !core_mute;
      ml_falls++;
    end
    if (!sck && sck_prev && core_done) out_sr = {out_sr[254:0], 1'b0};
    if (hash_valid) hv_cnt++;
    sck_prev = sck;
    bl_prev  = block_load;
    ml_prev  = message_load;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_block(input logic [511:0] b, input logic last);
    bit ok = 1'b0;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("blk_ready_wait", 256'(ok), 256'd1);
    blk_valid = 1'b1;
    block     = b;
    blk_last  = last;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_hash();
    bit ok = 1'b0;
    for (int g = 0; g < 30000; g++) begin
      @(negedge clk);
      if (hash_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("hash_valid_wait", 256'(ok), 256'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [511:0] b0;
    logic [511:0] b1;
    int           nblk;
    logic [255:0] exp;
  } vec_t;

  vec_t         vecs [3];
  logic [511:0] abc_blk, empty_blk, one_hot;
  int           hv0, mlf0, blf0;
  bit           hit;

  initial begin
    abc_blk   = {32'h61626380, 416'h0, 64'h18};
    empty_blk = {32'h80000000, 480'h0};
    one_hot   = '0;
    one_hot[511] = 1'b1;

    vecs[0].b0   = abc_blk;
    vecs[0].b1   = '0;
    vecs[0].nblk = 1;
    vecs[0].exp  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    vecs[1].b0   = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                    64'h8000000000000000};
    vecs[1].b1   = {448'h0, 64'h1c0};
    vecs[1].nblk = 2;
    vecs[1].exp  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    vecs[2].b0   = empty_blk;
    vecs[2].b1   = '0;
    vecs[2].nblk = 1;
    vecs[2].exp  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", 256'({sck, sdo, block_load, message_load, busy, hash_valid, blk_ready}), 256'd0);
    check("reset_hash", hash, 256'd0);
`ifdef UPCOIN_SPI_TIMEOUT_EN
    check("reset_timeout", 256'(timeout), 256'd0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 256'(blk_ready), 256'd1);

    // Reset in the middle of SHIFT
    hv0 = hv_cnt;
    send_block(abc_blk, 1'b1);
    repeat (2) @(negedge clk);
    hit = 1'b0;
    for (int g = 0; g < 5000; g++) begin
      @(posedge clk);
      #1;
      if (sh_blk == 200) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_bit200", 256'(hit), 256'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ctrl", 256'({sck, block_load, message_load, blk_ready, busy}), 256'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_hv", 256'(hv_cnt - hv0), 256'd0);
    check("abort_hash", hash, 256'd0);
    check("abort_idle_ready", 256'(blk_ready), 256'd1);

    // Table-driven messages
    for (int i = 0; i < 3; i++) begin
      hv0  = hv_cnt;
      mlf0 = ml_falls;
      blf0 = bl_falls;
      send_block(vecs[i].b0, vecs[i].nblk == 1);
      if (vecs[i].nblk == 2) send_block(vecs[i].b1, 1'b1);
      wait_hash();
      check($sformatf("hash_v%0d", i), hash, vecs[i].exp);
      check($sformatf("hv_pulses_v%0d", i), 256'(hv_cnt - hv0), 256'd1);
      check($sformatf("ml_falls_v%0d", i), 256'(ml_falls - mlf0), 256'd1);
      check($sformatf("bl_falls_v%0d", i), 256'(bl_falls - blf0), 256'(vecs[i].nblk));
      check($sformatf("busy_v%0d", i), 256'(busy), 256'd0);
    end

    // blk_valid pulses outside IDLE/NEXT are ignored
    hv0  = hv_cnt;
    blf0 = bl_falls;
    send_block(abc_blk, 1'b1);
    repeat (2) @(negedge clk);
    hit = 1'b0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge clk);
      if (sh_blk >= 20) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_shift", 256'(hit), 256'd1);
    check("shift_ready", 256'(blk_ready), 256'd0);
    blk_valid = 1'b1;
    block     = empty_blk;
    blk_last  = 1'b1;
    repeat (4) @(negedge clk);
    blk_valid = 1'b0;
    hit = 1'b0;
    for (int g = 0; g < 10000; g++) begin
      @(negedge clk);
      if (rd_rises >= 20) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_read", 256'(hit), 256'd1);
    check("read_ready", 256'(blk_ready), 256'd0);
    check("read_hash_held", hash, vecs[2].exp);
    blk_valid = 1'b1;
    repeat (4) @(negedge clk);
    blk_valid = 1'b0;
    wait_hash();
    check("ignored_hash", hash, vecs[0].exp);
    check("ignored_hv", 256'(hv_cnt - hv0), 256'd1);
    check("ignored_blocks", 256'(bl_falls - blf0), 256'd1);

    // Bit order and rise counts
    hv0 = hv_cnt;
    send_block(one_hot, 1'b1);
    wait_hash();
    check("shift_rises", 256'(sh_blk), 256'd512);
    check("shift_first_bit", 256'(first_bit), 256'd1);
    check("shift_ones", 256'(sh_ones), 256'd1);
    check("read_rises", 256'(rd_rises), 256'd256);
    check("onehot_hv", 256'(hv_cnt - hv0), 256'd1);

`ifdef UPCOIN_SPI_TIMEOUT_EN
    // done held low: watchdog fires after TIMEOUT cycles in WAIT_DONE
    core_mute = 1'b1;
    hv0 = hv_cnt;
    send_block(abc_blk, 1'b1);
    hit = 1'b0;
    for (int g = 0; g < 10000; g++) begin
      @(negedge clk);
      if (!message_load) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_release", 256'(hit), 256'd1);
    hit = 1'b0;
    for (int g = 1; g < 1000; g++) begin
      @(negedge clk);
      if (timeout) begin
        hit = 1'b1;
        check("timeout_cycles", 256'(g), 256'(TIMEOUT + 1));
        break;
      end
    end
    check("timeout_seen", 256'(hit), 256'd1);
    repeat (5) @(negedge clk);
    check("timeout_no_hv", 256'(hv_cnt - hv0), 256'd0);
    check("timeout_busy", 256'(busy), 256'd0);
    check("timeout_pulse", 256'(timeout), 256'd0);
    core_mute = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
